// File: rtl/serial_word_assembler_pkg.sv
// Shared constants for the serial word assembler and its upstream stage bench.
// FSM encoding plus default word/sync geometry.
package serial_word_assembler_pkg;

    localparam logic [1:0] HUNT     = 2'd0;
    localparam logic [1:0] ASSEMBLE = 2'd1;
    localparam logic [1:0] PARITY   = 2'd2;

    localparam int         DEF_WIDTH        = 8;
    localparam int         DEF_SYNC_LEN     = 8;
    localparam logic [7:0] DEF_SYNC_PATTERN = 8'hA5;
    localparam int         DEF_FRAME_WORDS  = 4;

endpackage

// File: rtl/serial_word_assembler_sync.sv
// Sliding-window sync pattern detector; overlapping patterns are found
// because the window keeps shifting on every enabled bit.
module sync_pattern_detector #(
    parameter int                   SYNC_LEN     = 8,
    parameter logic [SYNC_LEN-1:0]  SYNC_PATTERN = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    input  logic bit_in,
    output logic match
);

    // The oldest bit of the window is never compared, so it is not stored.
    logic [SYNC_LEN-2:0] window;
    logic [SYNC_LEN-1:0] window_nxt;

    assign window_nxt = {window, bit_in};
    assign match      = enable && (window_nxt == SYNC_PATTERN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window <= '0;
        end else if (clear) begin
            window <= '0;
        end else if (enable) begin
            window <= window_nxt[SYNC_LEN-2:0];
        end
    end

endmodule

// File: rtl/serial_word_assembler.sv
// Hunts for sync, packs FRAME_WORDS MSB-first words into a valid/ready register.
// Define SERIAL_WORD_ASSEMBLER_PARITY_EN for a per-word even-parity bit.
module serial_word_assembler
    import serial_word_assembler_pkg::*;
#(
    parameter int                  WIDTH        = DEF_WIDTH,
    parameter int                  SYNC_LEN     = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_LEN'(DEF_SYNC_PATTERN),
    parameter int                  FRAME_WORDS  = DEF_FRAME_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             sync_locked,
    output logic             overflow_err
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int BW  = $clog2(WIDTH);
    localparam int WCW = $clog2(FRAME_WORDS + 1);
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    localparam int SW  = WIDTH;
`else
    localparam int SW  = WIDTH - 1;
`endif

    logic [1:0]       state;
    logic [BW-1:0]    bit_cnt;
    logic [WCW-1:0]   word_cnt;
    logic [SW-1:0]    shreg;
    logic [SW-1:0]    shift_nxt;
    logic [WIDTH-1:0] new_word;

    logic hunt_en;
    logic sync_match;
    logic sync_clr;
    logic bit_last;
    logic frame_done;
    logic complete;
    logic par_fail;

    assign hunt_en    = bit_en && (state == HUNT);
    assign bit_last   = (bit_cnt == BW'(WIDTH - 1));
    assign frame_done = (word_cnt == WCW'(FRAME_WORDS - 1));

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    // The whole word is held in shreg while its parity bit is awaited.
    assign shift_nxt = {shreg[SW-2:0], bit_in};
    assign new_word  = shreg;
    assign complete  = bit_en && (state == PARITY) && !(^{shreg, bit_in});
    assign par_fail  = bit_en && (state == PARITY) && (^{shreg, bit_in});
`else
    // The last bit completes the word straight from the input.
    assign new_word  = {shreg, bit_in};
    assign shift_nxt = new_word[SW-1:0];
    assign complete  = bit_en && (state == ASSEMBLE) && bit_last;
    assign par_fail  = 1'b0;
`endif

    assign sync_clr    = (complete && frame_done) || par_fail;
    assign sync_locked = (state != HUNT);

    sync_pattern_detector #(
        .SYNC_LEN     (SYNC_LEN),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .enable (hunt_en),
        .clear  (sync_clr),
        .bit_in (bit_in),
        .match  (sync_match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HUNT;
            bit_cnt  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
        end else if (bit_en) begin
            case (state)
                HUNT: begin
                    if (sync_match) begin
                        state    <= ASSEMBLE;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end
                ASSEMBLE: begin
                    shreg <= shift_nxt;
                    if (bit_last) begin
                        bit_cnt <= '0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
                        state   <= PARITY;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
                PARITY: begin
                    state <= ASSEMBLE;
                end
`endif
                default: begin
                    state <= HUNT;
                end
            endcase
            // Frame end and parity failure override the per-state next state.
            if (complete) begin
                if (frame_done) begin
                    state    <= HUNT;
                    word_cnt <= '0;
                end else begin
                    word_cnt <= word_cnt + WCW'(1);
                end
            end
            if (par_fail) begin
                state <= HUNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_out     <= '0;
            word_valid   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (complete) begin
                if (!word_valid || word_ready) begin
                    word_out   <= new_word;
                    word_valid <= 1'b1;
                end else begin
                    overflow_err <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else if (par_fail) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule
